// File: rtl/pac_mapper_pkg.sv
// Shared types and fixed addresses for the FM-PAC page-1 mapper controller.
package pac_mapper_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, HOLD} state_t;

  localparam logic [15:0] BANK_ADDR = 16'h7FF7;
  localparam logic [15:0] KEY_ADDR  = 16'h5FFE;
  // {key1, key0} value that unlocks the battery SRAM
  localparam logic [15:0] KEY       = 16'h694D;

endpackage

// File: rtl/pac_ram_handshake.sv
// One RAM transaction: single-cycle REQ pulse, wait for ACK, abort after TIMEOUT busy cycles.
module pac_ram_handshake #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       clr,
  input  logic       go,
  input  logic       ack,
  input  logic [7:0] ram_dout,
  output logic       req,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic       busy_q;
  logic       req_q;
  logic [7:0] cnt_q;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      busy_q <= 1'b0;
      req_q  <= 1'b0;
      cnt_q  <= 8'h00;
    end else if (clr) begin
      busy_q <= 1'b0;
      req_q  <= 1'b0;
      cnt_q  <= 8'h00;
    end else begin
      req_q <= go && !busy_q;
      if (go && !busy_q) begin
        busy_q <= 1'b1;
        cnt_q  <= 8'h00;
      end else if (busy_q) begin
        if (ack || cnt_q == TO_LAST) begin
          busy_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 8'h01;
        end
      end
    end
  end

  // The REQ cycle counts toward the timeout, so WAIT_n is held for at most TIMEOUT cycles.
  assign req     = req_q;
  assign done    = busy_q && ack;
  assign timeout = busy_q && !ack && (cnt_q == TO_LAST);
  assign rdata   = ack ? ram_dout : 8'hFF;

endmodule

// File: rtl/pac_mapper_ctrl.sv
// FM-PAC page-1 controller: banked ROM plus key-unlocked 8KB SRAM, backed by external RAM
// through a REQ/ACK handshake with Z80 wait stretching and SRAM dirty tracking.
module pac_mapper_ctrl
  import pac_mapper_pkg::*;
#(
  parameter int unsigned RAM_AW        = 23,
  parameter int unsigned RAM_ADDR_ROM  = 0,
  parameter int unsigned RAM_ADDR_SRAM = 0,
  parameter int unsigned ROM_BANKS     = 4,
  parameter int unsigned TIMEOUT       = 255,
  parameter bit          WAIT_EN       = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              BUS_RESET_n,
  input  logic [15:0]       ADDR,
  input  logic [7:0]        DIN,
  input  logic              SLTSL_n,
  input  logic              MERQ_n,
  input  logic              RD_n,
  input  logic              WR_n,
  output logic [7:0]        DOUT,
  output logic              BUSDIR_n,
  output logic              WAIT_n,
  output logic [RAM_AW-1:0] RAM_ADDR,
  output logic [7:0]        RAM_DIN,
  output logic              RAM_WE,
  output logic              RAM_REQ,
  input  logic              RAM_ACK,
  input  logic [7:0]        RAM_DOUT,
  input  logic              CLR_DIRTY,
  output logic              SRAM_ENABLE,
  output logic              SRAM_DIRTY,
  output logic              TIMEOUT_ERR
);

  localparam int unsigned       BW        = (ROM_BANKS > 1) ? $clog2(ROM_BANKS) : 1;
  localparam logic [BW-1:0]     BANK_MASK = BW'(ROM_BANKS - 1);
  localparam logic [RAM_AW-1:0] ROM_BASE  = RAM_AW'(RAM_ADDR_ROM);
  localparam logic [RAM_AW-1:0] SRAM_BASE = RAM_AW'(RAM_ADDR_SRAM);

  state_t            state_q;
  logic              acc, acc_q, rd, is_bank, reg_access, use_sram, needs_ram, start;
  logic [7:0]        reg_rdata;
  logic [BW-1:0]     bank_q;
  logic [7:0]        key0_q, key1_q, dout_q, ram_din_q;
  logic              busdir_n_q, wait_n_q, ram_we_q, rd_q, sram_wr_q, dirty_q, timeout_err_q;
  logic [RAM_AW-1:0] ram_addr_q, rom_addr, sram_addr;
  logic              hs_done, hs_timeout;
  logic [7:0]        hs_rdata;

  assign acc         = !SLTSL_n && !MERQ_n && (!RD_n || !WR_n) && (ADDR[15:14] == 2'b01);
  assign rd          = !RD_n;
  assign start       = (state_q == IDLE) && acc && !acc_q;
  assign SRAM_ENABLE = ({key1_q, key0_q} == KEY);
  assign is_bank     = (ADDR == BANK_ADDR);
  assign rom_addr    = ROM_BASE | RAM_AW'({bank_q, ADDR[13:0]});
  assign sram_addr   = SRAM_BASE | RAM_AW'(ADDR[12:0]);

  // Key registers only read back while unlocked; otherwise those addresses fall through to ROM.
  always_comb begin
    reg_access = 1'b0;
    use_sram   = 1'b0;
    reg_rdata  = 8'h00;
    if (is_bank) begin
      reg_access = 1'b1;
      reg_rdata  = 8'(bank_q);
    end else if ((ADDR[15:1] == KEY_ADDR[15:1]) && (!rd || SRAM_ENABLE)) begin
      reg_access = 1'b1;
      reg_rdata  = ADDR[0] ? key1_q : key0_q;
    end else if (!ADDR[13] && SRAM_ENABLE) begin
      use_sram = 1'b1;
    end
  end

  assign needs_ram = !reg_access && (rd || use_sram);

  pac_ram_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_handshake (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .clr      (!BUS_RESET_n),
    .go       (start && needs_ram),
    .ack      (RAM_ACK),
    .ram_dout (RAM_DOUT),
    .req      (RAM_REQ),
    .done     (hs_done),
    .timeout  (hs_timeout),
    .rdata    (hs_rdata)
  );

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= IDLE;
      acc_q         <= 1'b0;
      bank_q        <= '0;
      key0_q        <= 8'h00;
      key1_q        <= 8'h00;
      dout_q        <= 8'h00;
      busdir_n_q    <= 1'b1;
      wait_n_q      <= 1'b1;
      ram_addr_q    <= '0;
      ram_din_q     <= 8'h00;
      ram_we_q      <= 1'b0;
      rd_q          <= 1'b0;
      sram_wr_q     <= 1'b0;
      dirty_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (CLR_DIRTY) dirty_q <= 1'b0;
      if (!BUS_RESET_n) begin
        // Dirty state deliberately survives a bus reset so pending save-back is not lost.
        state_q       <= IDLE;
        acc_q         <= 1'b0;
        bank_q        <= '0;
        key0_q        <= 8'h00;
        key1_q        <= 8'h00;
        dout_q        <= 8'h00;
        busdir_n_q    <= 1'b1;
        wait_n_q      <= 1'b1;
        ram_addr_q    <= '0;
        ram_din_q     <= 8'h00;
        ram_we_q      <= 1'b0;
        rd_q          <= 1'b0;
        sram_wr_q     <= 1'b0;
        timeout_err_q <= 1'b0;
      end else begin
        acc_q <= acc;
        unique case (state_q)
          IDLE: begin
            if (start) begin
              rd_q <= rd;
              if (reg_access) begin
                if (rd) begin
                  dout_q     <= reg_rdata;
                  busdir_n_q <= 1'b0;
                end else if (is_bank) begin
                  bank_q <= DIN[BW-1:0] & BANK_MASK;
                end else if (ADDR[0]) begin
                  key1_q <= DIN;
                end else begin
                  key0_q <= DIN;
                end
                state_q <= HOLD;
              end else if (needs_ram) begin
                ram_addr_q <= use_sram ? sram_addr : rom_addr;
                ram_we_q   <= !rd;
                ram_din_q  <= DIN;
                sram_wr_q  <= use_sram && !rd;
                wait_n_q   <= !WAIT_EN;
                state_q    <= REQ;
              end else begin
                state_q <= HOLD;
              end
            end
          end
          REQ, WAIT_ACK: begin
            if (hs_done || hs_timeout) begin
              wait_n_q <= 1'b1;
              ram_we_q <= 1'b0;
              if (hs_timeout) timeout_err_q <= 1'b1;
              if (hs_done && sram_wr_q) dirty_q <= 1'b1;
              if (acc) begin
                state_q <= HOLD;
                if (rd_q) begin
                  dout_q     <= hs_rdata;
                  busdir_n_q <= 1'b0;
                end
              end else begin
                state_q <= IDLE;
              end
            end else begin
              state_q <= WAIT_ACK;
            end
          end
          HOLD: begin
            if (!acc) begin
              state_q    <= IDLE;
              dout_q     <= 8'h00;
              busdir_n_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign DOUT        = dout_q;
  assign BUSDIR_n    = busdir_n_q;
  assign WAIT_n      = wait_n_q;
  assign RAM_ADDR    = ram_addr_q;
  assign RAM_DIN     = ram_din_q;
  assign RAM_WE      = ram_we_q;
  assign SRAM_DIRTY  = dirty_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_pac_mapper_ctrl.sv
// Scoreboard bench for pac_mapper_ctrl: expected RAM requests and read data are queued
// when a bus cycle is driven and compared when the DUT issues REQ or drives the bus.
module tb_pac_mapper_ctrl;

  localparam int unsigned AW        = 23;
  localparam logic [22:0] ROM_BASE  = 23'h100000;
  localparam logic [22:0] SRAM_BASE = 23'h200000;

  typedef struct packed {
    logic        we;
    logic [22:0] addr;
    logic [7:0]  din;
  } ram_exp_t;

  logic        CLK = 1'b0;
  logic        RESET_n, BUS_RESET_n;
  logic [15:0] ADDR;
  logic [7:0]  DIN;
  logic        SLTSL_n, MERQ_n, RD_n, WR_n;
  logic [7:0]  DOUT;
  logic        BUSDIR_n, WAIT_n;
  logic [22:0] RAM_ADDR;
  logic [7:0]  RAM_DIN;
  logic        RAM_WE, RAM_REQ, RAM_ACK;
  logic [7:0]  RAM_DOUT;
  logic        CLR_DIRTY, SRAM_ENABLE, SRAM_DIRTY, TIMEOUT_ERR;

  ram_exp_t   ram_q[$];
  logic [7:0] rd_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         ack_delay = 0;
  int         ack_cnt = -1;
  int         wait_low = 0;
  logic [7:0] ram_rdata = 8'h00;
  logic       late_ack = 1'b0;
  logic       clr_req = 1'b0;
  logic       clr_with_ack = 1'b0;
  logic       busdir_prev = 1'b1;

  pac_mapper_ctrl #(
    .RAM_AW        (AW),
    .RAM_ADDR_ROM  (32'h0010_0000),
    .RAM_ADDR_SRAM (32'h0020_0000),
    .ROM_BANKS     (4),
    .TIMEOUT       (8),
    .WAIT_EN       (1'b1)
  ) dut (
    .CLK         (CLK),
    .RESET_n     (RESET_n),
    .BUS_RESET_n (BUS_RESET_n),
    .ADDR        (ADDR),
    .DIN         (DIN),
    .SLTSL_n     (SLTSL_n),
    .MERQ_n      (MERQ_n),
    .RD_n        (RD_n),
    .WR_n        (WR_n),
    .DOUT        (DOUT),
    .BUSDIR_n    (BUSDIR_n),
    .WAIT_n      (WAIT_n),
    .RAM_ADDR    (RAM_ADDR),
    .RAM_DIN     (RAM_DIN),
    .RAM_WE      (RAM_WE),
    .RAM_REQ     (RAM_REQ),
    .RAM_ACK     (RAM_ACK),
    .RAM_DOUT    (RAM_DOUT),
    .CLR_DIRTY   (CLR_DIRTY),
    .SRAM_ENABLE (SRAM_ENABLE),
    .SRAM_DIRTY  (SRAM_DIRTY),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // RAM responder and bus monitor, all sampling on the falling edge.
  initial begin
    ram_exp_t e;
    RAM_ACK   = 1'b0;
    RAM_DOUT  = 8'h00;
    CLR_DIRTY = 1'b0;
    forever begin
      @(negedge CLK);
      RAM_ACK   = 1'b0;
      CLR_DIRTY = 1'b0;
      if (clr_req) begin
        CLR_DIRTY = 1'b1;
        clr_req   = 1'b0;
      end
      if (RAM_REQ) begin
        if (ram_q.size() == 0) begin
          check("unexpected_req", 1, 0);
        end else begin
          e = ram_q.pop_front();
          check("ram_addr", RAM_ADDR, e.addr);
          check("ram_we", RAM_WE, e.we);
          if (e.we) check("ram_din", RAM_DIN, e.din);
        end
        ack_cnt = ack_delay;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
      end
      if (ack_cnt == 0 || late_ack) begin
        RAM_ACK  = 1'b1;
        RAM_DOUT = ram_rdata;
        ack_cnt  = -1;
        late_ack = 1'b0;
        if (clr_with_ack) begin
          CLR_DIRTY    = 1'b1;
          clr_with_ack = 1'b0;
        end
      end
      if (!WAIT_n) wait_low++;
      if (!BUSDIR_n && busdir_prev) begin
        if (rd_q.size() == 0) check("unexpected_drive", 1, 0);
        else check("read_data", DOUT, rd_q.pop_front());
      end
      busdir_prev = BUSDIR_n;
    end
  end

  task automatic release_bus();
    SLTSL_n = 1'b1;
    MERQ_n  = 1'b1;
    RD_n    = 1'b1;
    WR_n    = 1'b1;
  endtask

  task automatic access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                        input logic exp_req, input logic [22:0] exp_addr,
                        input logic [7:0] exp_rd, input logic drop);
    ram_exp_t e;
    int n;
    e = '{we: wr, addr: exp_addr, din: d};
    if (exp_req) ram_q.push_back(e);
    if (!wr && !drop) rd_q.push_back(exp_rd);
    @(posedge CLK); #1;
    ADDR = a; DIN = d; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = wr; WR_n = !wr;
    wait_low = 0;
    repeat (2) @(negedge CLK);
    if (drop) begin
      @(posedge CLK); #1;
      release_bus();
    end
    n = 0;
    while (!WAIT_n && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 300) check("wait_release_bound", 0, 1);
    if (!drop) begin
      @(posedge CLK); #1;
      release_bus();
    end
    repeat (2) @(negedge CLK);
    check("idle_dout", DOUT, 0);
    check("idle_busdir", BUSDIR_n, 1);
    check("ram_q_drained", ram_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_n = 1'b0; BUS_RESET_n = 1'b1; ADDR = 16'h0000; DIN = 8'h00;
    release_bus();
    repeat (3) @(negedge CLK);
    check("rst_dout", DOUT, 0);
    check("rst_busdir", BUSDIR_n, 1);
    check("rst_wait", WAIT_n, 1);
    check("rst_req", RAM_REQ, 0);
    check("rst_we", RAM_WE, 0);
    check("rst_addr", RAM_ADDR, 0);
    check("rst_sram_en", SRAM_ENABLE, 0);
    check("rst_dirty", SRAM_DIRTY, 0);
    check("rst_timeout", TIMEOUT_ERR, 0);
    @(posedge CLK); #1;
    RESET_n = 1'b1;

    // Basic ROM read, ACK two cycles after the REQ cycle
    ack_delay = 2; ram_rdata = 8'hA5;
    access(1'b0, 16'h4000, 8'h00, 1'b1, ROM_BASE, 8'hA5, 1'b0);
    check("wait_low_rd", wait_low, 3);

    // Strobe dropped mid-handshake: handshake completes, nothing driven
    ack_delay = 4; ram_rdata = 8'h11;
    access(1'b0, 16'h4020, 8'h00, 1'b1, ROM_BASE + 23'h0020, 8'h00, 1'b1);
    check("wait_low_drop", wait_low, 5);

    // Bank register
    ack_delay = 0;
    access(1'b1, 16'h7FF7, 8'h02, 1'b0, '0, 8'h00, 1'b0);
    ram_rdata = 8'h3C;
    access(1'b0, 16'h4123, 8'h00, 1'b1, ROM_BASE + 23'h8123, 8'h3C, 1'b0);
    access(1'b0, 16'h7FF7, 8'h00, 1'b0, '0, 8'h02, 1'b0);
    access(1'b1, 16'h7FF7, 8'h07, 1'b0, '0, 8'h00, 1'b0);
    access(1'b0, 16'h7FF7, 8'h00, 1'b0, '0, 8'h03, 1'b0);
    ack_delay = 1; ram_rdata = 8'hC3;
    access(1'b0, 16'h7FFF, 8'h00, 1'b1, ROM_BASE + 23'hFFFF, 8'hC3, 1'b0);

    // SRAM unlock and write
    access(1'b1, 16'h5FFE, 8'h4D, 1'b0, '0, 8'h00, 1'b0);
    check("key_half_locked", SRAM_ENABLE, 0);
    access(1'b1, 16'h5FFF, 8'h69, 1'b0, '0, 8'h00, 1'b0);
    check("sram_enable", SRAM_ENABLE, 1);
    access(1'b0, 16'h5FFE, 8'h00, 1'b0, '0, 8'h4D, 1'b0);
    access(1'b1, 16'h4010, 8'h77, 1'b1, SRAM_BASE + 23'h0010, 8'h00, 1'b0);
    check("dirty_after_wr", SRAM_DIRTY, 1);
    check("wait_low_wr", wait_low, 2);
    ack_delay = 0; ram_rdata = 8'h9E;
    access(1'b0, 16'h5FFD, 8'h00, 1'b1, SRAM_BASE + 23'h1FFD, 8'h9E, 1'b0);
    ram_rdata = 8'h66;
    access(1'b0, 16'h6000, 8'h00, 1'b1, ROM_BASE + 23'hE000, 8'h66, 1'b0);

    // Dirty clear, then clear coincident with a write ACK
    @(posedge CLK); #1; clr_req = 1'b1;
    repeat (3) @(negedge CLK);
    check("dirty_cleared", SRAM_DIRTY, 0);
    ack_delay = 1; clr_with_ack = 1'b1;
    access(1'b1, 16'h4020, 8'h55, 1'b1, SRAM_BASE + 23'h0020, 8'h00, 1'b0);
    check("dirty_set_wins", SRAM_DIRTY, 1);

    // Relock: SRAM window reverts to ROM (bank 3)
    access(1'b1, 16'h5FFE, 8'h00, 1'b0, '0, 8'h00, 1'b0);
    check("sram_relocked", SRAM_ENABLE, 0);
    ack_delay = 0; ram_rdata = 8'h12;
    access(1'b0, 16'h4010, 8'h00, 1'b1, ROM_BASE + 23'hC010, 8'h12, 1'b0);

    // Timeout: no ACK
    ack_delay = -1;
    access(1'b0, 16'h4000, 8'h00, 1'b1, ROM_BASE + 23'hC000, 8'hFF, 1'b0);
    check("wait_low_timeout", wait_low, 8);
    check("timeout_err", TIMEOUT_ERR, 1);
    @(posedge CLK); #1; late_ack = 1'b1;
    repeat (3) @(negedge CLK);
    check("late_ack_wait", WAIT_n, 1);
    check("late_ack_busdir", BUSDIR_n, 1);
    check("late_ack_dout", DOUT, 0);
    ack_delay = 0; ram_rdata = 8'h5A;
    access(1'b0, 16'h4001, 8'h00, 1'b1, ROM_BASE + 23'hC001, 8'h5A, 1'b0);
    check("wait_low_ack0", wait_low, 1);
    check("timeout_sticky", TIMEOUT_ERR, 1);

    // Bus reset while waiting for ACK
    access(1'b1, 16'h7FF7, 8'h01, 1'b0, '0, 8'h00, 1'b0);
    access(1'b1, 16'h5FFE, 8'h4D, 1'b0, '0, 8'h00, 1'b0);
    access(1'b1, 16'h5FFF, 8'h69, 1'b0, '0, 8'h00, 1'b0);
    ack_delay = -1;
    ram_q.push_back('{we: 1'b0, addr: ROM_BASE + 23'h6200, din: 8'h00});
    @(posedge CLK); #1;
    ADDR = 16'h6200; SLTSL_n = 1'b0; MERQ_n = 1'b0; RD_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("busrst_waiting", WAIT_n, 0);
    @(posedge CLK); #1;
    BUS_RESET_n = 1'b0;
    release_bus();
    @(posedge CLK); #1;
    BUS_RESET_n = 1'b1;
    @(negedge CLK);
    check("busrst_wait", WAIT_n, 1);
    check("busrst_ram_addr", RAM_ADDR, 0);
    check("busrst_sram_en", SRAM_ENABLE, 0);
    check("busrst_timeout", TIMEOUT_ERR, 0);
    check("busrst_dirty_kept", SRAM_DIRTY, 1);
    check("busrst_busdir", BUSDIR_n, 1);
    repeat (12) @(negedge CLK);
    check("busrst_no_late_timeout", TIMEOUT_ERR, 0);
    ack_delay = 0;
    access(1'b0, 16'h7FF7, 8'h00, 1'b0, '0, 8'h00, 1'b0);

    check("final_ram_q", ram_q.size(), 0);
    check("final_rd_q", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
